// File: rtl/mem_io_bridge_pkg.sv
// Shared SLC-3 memory bridge definitions: bridge state encoding and address map defaults.
package mem_io_bridge_pkg;

    localparam int unsigned DATA_W         = 16;
    localparam int unsigned ADDR_W         = 16;
    localparam int unsigned CNT_W          = 3;
    localparam logic [15:0] IO_ADDR_DFLT   = 16'hFFFF;
    localparam int unsigned RD_LAT_DFLT    = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        IO_WAIT = 2'd2,
        DONE    = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/mem_io_bridge_sync_2ff.sv
// Two-flop synchroniser for a multi-bit quasi-static input, synchronous reset to zero.
module sync_2ff #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mem_io_bridge.sv
// Bridges the SLC-3 control FSM's MAR/MDR memory requests onto a BRAM port and a
// single memory-mapped I/O address (switches on read, hex display on write).
module mem_io_bridge
    import mem_io_bridge_pkg::*;
#(
    parameter logic [15:0] IO_ADDR = IO_ADDR_DFLT,
    parameter int unsigned RD_LAT  = RD_LAT_DFLT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_mem_ena,
    input  logic        mem_wr_ena,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic [15:0] sw_i,
    input  logic [15:0] bram_dout,
    output logic        bram_en,
    output logic        bram_we,
    output logic [15:0] bram_addr,
    output logic [15:0] bram_din,
    output logic [15:0] rdata,
    output logic        mem_rdy,
    output logic [15:0] hex_o
);

    bridge_state_e     state_q, state_d;
    logic              arm_q, arm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] hex_q, hex_d;
    logic              wr_rdy_q, wr_rdy_d;

    logic [DATA_W-1:0] sw_sync;
    logic [DATA_W-1:0] rd_src;
    logic              is_io;
    logic              accept;
    logic              rd_fin;

    sync_2ff #(.WIDTH(DATA_W)) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw_i),
        .q     (sw_sync)
    );

    // Next-state: only the transaction type is captured, addr/wdata are consumed in the accept cycle.
    always_comb begin
        state_d  = state_q;
        arm_d    = arm_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        hex_d    = hex_q;
        wr_rdy_d = 1'b0;

        is_io  = (addr == IO_ADDR);
        accept = !reset && (state_q == IDLE) && mem_mem_ena && arm_q;
        rd_fin = !reset && ((state_q == RD_WAIT) || (state_q == IO_WAIT))
                 && (cnt_q == CNT_W'(RD_LAT));
        rd_src = (state_q == IO_WAIT) ? sw_sync : bram_dout;

        if (!mem_mem_ena) begin
            arm_d = 1'b1;
        end else if (accept) begin
            arm_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (mem_wr_ena) begin
                        state_d  = DONE;
                        wr_rdy_d = 1'b1;
                        if (is_io) begin
                            hex_d = wdata;
                        end
                    end else begin
                        state_d = is_io ? IO_WAIT : RD_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            RD_WAIT, IO_WAIT: begin
                if (rd_fin) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    rdata_d = rd_src;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            arm_q    <= 1'b1;
            cnt_q    <= '0;
            rdata_q  <= '0;
            hex_q    <= '0;
            wr_rdy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            arm_q    <= arm_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            hex_q    <= hex_d;
            wr_rdy_q <= wr_rdy_d;
        end
    end

    // Read data is forwarded in its completion cycle so the MDR can load alongside mem_rdy.
    assign bram_en   = accept && !is_io;
    assign bram_we   = accept && !is_io && mem_wr_ena;
    assign bram_addr = addr;
    assign bram_din  = wdata;
    assign rdata     = rd_fin ? rd_src : rdata_q;
    assign mem_rdy   = rd_fin || (wr_rdy_q && !reset);
    assign hex_o     = hex_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Randomised self-checking bench for mem_io_bridge against a transaction-level memory model.
module tb_mem_io_bridge;

    localparam logic [15:0] IO_A = 16'hFFFF;
    localparam int          LAT  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_mem_ena;
    logic        mem_wr_ena;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] sw_i;
    logic [15:0] bram_dout;
    logic        bram_en;
    logic        bram_we;
    logic [15:0] bram_addr;
    logic [15:0] bram_din;
    logic [15:0] rdata;
    logic        mem_rdy;
    logic [15:0] hex_o;

    mem_io_bridge dut (
        .clk         (clk),
        .reset       (reset),
        .mem_mem_ena (mem_mem_ena),
        .mem_wr_ena  (mem_wr_ena),
        .addr        (addr),
        .wdata       (wdata),
        .sw_i        (sw_i),
        .bram_dout   (bram_dout),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .rdata       (rdata),
        .mem_rdy     (mem_rdy),
        .hex_o       (hex_o)
    );

    always #5 clk = ~clk;

    // Environment BRAM with registered output: data appears two cycles after the read enable.
    logic [15:0] bram_mem [0:65535];
    logic [15:0] bram_r1;
    logic        pre_we;
    logic [15:0] pre_a;
    logic [15:0] pre_d;

    always @(posedge clk) begin
        if (pre_we) bram_mem[pre_a] <= pre_d;
        else if (bram_en) begin
            if (bram_we) bram_mem[bram_addr] <= bram_din;
            else         bram_r1 <= bram_mem[bram_addr];
        end
        bram_dout <= bram_r1;
    end

    int rdy_seen = 0;
    always @(negedge clk) if (mem_rdy === 1'b1) rdy_seen++;

    // Reference state
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] pool [$];
    logic [15:0] exp_rd;
    logic [15:0] exp_hex;
    int          exp_rdy;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            mem_mem_ena = 1'b0;
            @(negedge clk);
            check("idle_en", 16'(bram_en), 16'd0);
        end
    endtask

    // One transaction: accept in the first cycle, ena held for 'hold' cycles, inputs scrambled afterwards.
    task automatic do_txn(input bit wr, input logic [15:0] a, input logic [15:0] d, input int hold);
        bit          io;
        int          lat;
        int          last;
        logic [15:0] old_rd;
        logic [15:0] old_hex;
        io      = (a == IO_A);
        lat     = wr ? 1 : LAT;
        last    = (hold > lat + 1) ? hold : lat + 1;
        old_rd  = exp_rd;
        old_hex = exp_hex;

        @(posedge clk); #1;
        reset       = 1'b0;
        mem_mem_ena = 1'b1;
        mem_wr_ena  = wr;
        addr        = a;
        wdata       = d;
        @(negedge clk);
        check("acc_en", 16'(bram_en), 16'(!io));
        check("acc_we", 16'(bram_we), 16'(wr && !io));
        check("acc_rdy", 16'(mem_rdy), 16'd0);
        check("acc_rdata", rdata, old_rd);
        check("acc_hex", hex_o, old_hex);
        if (!io) check("acc_addr", bram_addr, a);
        if (wr && !io) check("acc_din", bram_din, d);

        if (wr) begin
            if (io) exp_hex = d;
            else    ref_mem[a] = d;
        end else begin
            exp_rd = io ? sw_i : ref_mem[a];
        end
        exp_rdy++;

        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            if (k < hold)      mem_mem_ena = 1'b1;
            else if (k <= lat) mem_mem_ena = 1'($urandom_range(0, 1));
            else               mem_mem_ena = 1'b0;
            mem_wr_ena = 1'($urandom_range(0, 1));
            addr       = 16'($urandom);
            wdata      = 16'($urandom);
            @(negedge clk);
            check("busy_rdy", 16'(mem_rdy), 16'(k == lat));
            check("busy_en", 16'(bram_en), 16'd0);
            check("busy_we", 16'(bram_we), 16'd0);
            check("busy_rdata", rdata, (!wr && k < lat) ? old_rd : exp_rd);
            check("busy_hex", hex_o, exp_hex);
        end
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] d;
        int          r;
        int          hold;
        n_checks    = 0;
        n_errors    = 0;
        exp_rdy     = 0;
        exp_rd      = 16'h0000;
        exp_hex     = 16'h0000;
        reset       = 1'b1;
        mem_mem_ena = 1'b1;
        mem_wr_ena  = 1'b0;
        addr        = 16'h3000;
        wdata       = 16'h0000;
        sw_i        = 16'h0000;
        pre_we      = 1'b1;
        pre_a       = 16'h3000;
        pre_d       = 16'h1234;
        bram_r1     = 16'h0000;
        ref_mem[16'h3000] = 16'h1234;
        pool.push_back(16'h3000);

        repeat (3) @(posedge clk);
        #1 pre_we = 1'b0;
        @(negedge clk);
        check("rst_rdy", 16'(mem_rdy), 16'd0);
        check("rst_en", 16'(bram_en), 16'd0);
        check("rst_we", 16'(bram_we), 16'd0);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_hex", hex_o, 16'h0000);
        @(posedge clk); #1;
        reset       = 1'b0;
        mem_mem_ena = 1'b0;
        @(negedge clk);

        // Directed scenarios
        do_txn(1'b0, 16'h3000, 16'h0000, 3);
        check("rd_1234", rdata, 16'h1234);
        do_txn(1'b1, 16'h3001, 16'hBEEF, 1);
        pool.push_back(16'h3001);
        do_txn(1'b0, 16'h3001, 16'h0000, 1);
        check("rd_beef", rdata, 16'hBEEF);
        sw_i = 16'h00A5;
        idle(3);
        do_txn(1'b0, IO_A, 16'h0000, 1);
        check("io_rd", rdata, 16'h00A5);
        do_txn(1'b1, IO_A, 16'h0042, 1);
        check("hex_42", hex_o, 16'h0042);
        do_txn(1'b1, 16'h3002, 16'h1111, 1);
        pool.push_back(16'h3002);
        check("hex_kept", hex_o, 16'h0042);
        do_txn(1'b0, 16'h3000, 16'h0000, 10);
        do_txn(1'b0, 16'h3001, 16'h0000, 1);
        do_txn(1'b0, 16'hFFFE, 16'h0000, 1);

        // Reset during a read: aborted, then a new read accepted right after release
        @(posedge clk); #1;
        mem_mem_ena = 1'b1;
        mem_wr_ena  = 1'b0;
        addr        = 16'h3000;
        @(negedge clk);
        check("ra_acc_en", 16'(bram_en), 16'd1);
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            reset = 1'b1;
            @(negedge clk);
            check("ra_rdy", 16'(mem_rdy), 16'd0);
            check("ra_en", 16'(bram_en), 16'd0);
        end
        check("ra_rdata", rdata, 16'h0000);
        check("ra_hex", hex_o, 16'h0000);
        exp_rd  = 16'h0000;
        exp_hex = 16'h0000;
        do_txn(1'b0, 16'h3002, 16'h0000, 2);

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            r    = int'($urandom_range(0, 9));
            hold = int'($urandom_range(1, 5));
            if (r < 3) begin
                a = 16'($urandom);
                if ($urandom_range(0, 7) == 0) a = 16'hFFFE;
                if (a == IO_A) a = 16'h3000;
                d = 16'($urandom);
                do_txn(1'b1, a, d, hold);
                pool.push_back(a);
            end else if (r < 6) begin
                a = pool[$urandom_range(0, pool.size() - 1)];
                do_txn(1'b0, a, 16'($urandom), hold);
            end else if (r < 8) begin
                sw_i = 16'($urandom);
                idle(3);
                do_txn(1'b0, IO_A, 16'($urandom), hold);
            end else begin
                do_txn(1'b1, IO_A, 16'($urandom), hold);
            end
        end

        idle(2);
        check("rdy_count", 16'(rdy_seen), 16'(exp_rdy));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 SHALL have parameter IO_ADDR, default 16'hFFFF: the single memory-mapped I/O address.
REQ-002 SHALL have parameter RD_LAT, default 2: cycles from read accept to data valid; legal range 2..7.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port mem_mem_ena, input, 1 bit: memory operation request from the control FSM.
REQ-006 SHALL have port mem_wr_ena, input, 1 bit: the request is a write; sampled with mem_mem_ena.
REQ-007 SHALL have port addr, input, 16 bits: MAR value.
REQ-008 SHALL have port wdata, input, 16 bits: MDR value.
REQ-009 SHALL have port sw_i, input, 16 bits: asynchronous board switches.
REQ-010 SHALL have port bram_dout, input, 16 bits: BRAM read data, output-registered.
REQ-011 SHALL have ports bram_en (1), bram_we (1), bram_addr (16) and bram_din (16), all outputs, driving the BRAM port.
REQ-012 SHALL have port rdata, output, 16 bits: read result, feeds the MDR input mux.
REQ-013 SHALL have port mem_rdy, output, 1 bit: one-cycle transaction-complete pulse.
REQ-014 SHALL have port hex_o, output, 16 bits: hex-display register.

Function
REQ-015 SHALL implement the states IDLE, RD_WAIT, IO_WAIT and DONE.
REQ-016 SHALL accept a request in a cycle T only when all of these hold: the state is IDLE, mem_mem_ena=1 and the arm flag is 1.
REQ-017 SHALL clear the arm flag on every accept and set it in any cycle with mem_mem_ena=0, so a level held for several cycles is one request.
REQ-018 SHALL, on a BRAM read accept (addr!=IO_ADDR, mem_wr_ena=0), drive bram_en=1, bram_we=0 and bram_addr=addr combinationally in cycle T, then enter RD_WAIT.
REQ-019 SHALL count RD_WAIT with a 3-bit counter; in cycle T+RD_LAT it SHALL drive rdata from bram_dout and mem_rdy=1, then register rdata and enter DONE.
REQ-020 SHALL, on a BRAM write accept (addr!=IO_ADDR), drive bram_en=1, bram_we=1, bram_addr=addr and bram_din=wdata in cycle T, assert mem_rdy in T+1 and enter DONE.
REQ-021 SHALL, on an I/O read accept, register the two-flop-synchronised sw_i into rdata and assert mem_rdy in T+RD_LAT via IO_WAIT, so latency is uniform; the BRAM SHALL NOT be enabled.
REQ-022 SHALL, on an I/O write accept, load hex_o<=wdata at the end of T and assert mem_rdy in T+1; the BRAM SHALL NOT be enabled.
REQ-023 SHALL move from DONE to IDLE unconditionally after one cycle; accept SHALL NOT occur in DONE.
REQ-024 SHALL hold rdata stable from mem_rdy until the next read completes; writes SHALL NOT alter rdata.
REQ-025 SHALL complete an accepted transaction with its captured addr, wdata and type even if mem_mem_ena falls or the inputs change mid-transaction.
REQ-026 SHALL ignore a request arriving while busy, with no queueing; the arm flag still tracks the level.
REQ-027 SHALL drive bram_en=0 and bram_we=0 in every cycle other than an accept cycle.
REQ-028 SHALL compare addresses on the full 16 bits; address wrap-around is not applicable.

Reset
REQ-029 SHALL, while reset=1, force state=IDLE, arm=1, counter=0, rdata=0, hex_o=0, the synchroniser flops=0, mem_rdy=0 and bram_en=bram_we=0.
REQ-030 SHALL, on reset asserted mid-transaction, abort the transaction with no mem_rdy and no hex_o update, and accept a request in the first cycle after reset is released.

Structure
REQ-031 SHALL place the state enum, IO_ADDR and the RD_LAT default in the shared SLC-3 package, used by both control and cpu.
REQ-032 SHALL instantiate one sub-module, sync_2ff (16 bits wide, reset to 0), for sw_i.

Verification
REQ-033 SHALL cover: BRAM preloaded with x3000=16'h1234; read addr=16'h3000 with ena held 3 cycles -> bram_en pulses once at T, mem_rdy at T+2, rdata=16'h1234.
REQ-034 SHALL cover: write addr=16'h3001 with wdata=16'hBEEF, then read the same address -> bram_we=1 only at T, mem_rdy at T+1, read returns 16'hBEEF.
REQ-035 SHALL cover: sw_i=16'h00A5 stable for 3 cycles, then read IO_ADDR -> rdata=16'h00A5 at T+2 and bram_en stays 0.
REQ-036 SHALL cover: write IO_ADDR with wdata=16'h0042 -> hex_o=16'h0042 from T+1; a following BRAM write SHALL leave hex_o unchanged.
REQ-037 SHALL cover: ena held high for 10 cycles -> exactly one mem_rdy; after ena drops for 1 cycle and rises again, a second transaction occurs.
REQ-038 SHALL cover: reset asserted at T+1 of a read -> no mem_rdy, rdata=0, state IDLE, and a new read accepted in the first cycle after release.
